// File: rtl/wb_arbiter_2way_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter:
// grant-state encoding and the default read data returned on a watchdog abort.
package wb_arbiter_2way_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } gnt_state_t;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          DATA_WIDTH           = 32;
  localparam int          SEL_WIDTH            = 4;

endpackage

// File: rtl/wb_arbiter_2way_if.sv
// Classic single-beat Wishbone bus bundle; master modport drives the request,
// slave modport answers it.
interface wb_arbiter_2way_if #(
  parameter int ADDR_WIDTH = 32
);
  import wb_arbiter_2way_pkg::*;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [ADDR_WIDTH-1:0] adr;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dat_r;

  modport master (output cyc, stb, we, sel, dat_w, adr, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, dat_w, adr, output ack, dat_r);

endinterface

// File: rtl/wb_arbiter_2way_rr_arb2.sv
// Round-robin grant FSM for two requesters; a grant is held until its owner
// drops the request, so multi-beat cycles are never split.
module wb_rr_arb2
  import wb_arbiter_2way_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  gnt_state_t state;
  logic       last_b;

  // Grant state, fairness pointer and registered grant outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      last_b  <= 1'b1;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state   <= ST_GNT_A;
            last_b  <= 1'b0;
            grant_a <= 1'b1;
            grant_b <= 1'b0;
          end else if (req_b) begin
            state   <= ST_GNT_B;
            last_b  <= 1'b1;
            grant_a <= 1'b0;
            grant_b <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GNT_A: begin
          if (req_a) begin
            state <= ST_GNT_A;
          end else if (req_b) begin
            state   <= ST_GNT_B;
            last_b  <= 1'b1;
            grant_a <= 1'b0;
            grant_b <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
          end
        end
        ST_GNT_B: begin
          if (req_b) begin
            state <= ST_GNT_B;
          end else if (req_a) begin
            state   <= ST_GNT_A;
            last_b  <= 1'b0;
            grant_a <= 1'b1;
            grant_b <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter_2way.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for a whole
// cycle, zero-latency pass-through datapath and an optional hung-transfer watchdog.
module wb_arbiter_2way
  import wb_arbiter_2way_pkg::*;
#(
  parameter int              ADDR_WIDTH     = 32,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter int              TIMEOUT_WIDTH  = 8,
  parameter logic [31:0]     TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  wb_arbiter_2way_if.slave         wbs_a,
  wb_arbiter_2way_if.slave         wbs_b,
  wb_arbiter_2way_if.master        wbm,
  output logic                     timeout_o
);

  localparam bit                     WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_CYCLES[TIMEOUT_WIDTH-1:0];

  logic                     grant_a;
  logic                     grant_b;
  logic                     m_cyc_s;
  logic                     m_stb_s;
  logic                     m_we_s;
  logic [SEL_WIDTH-1:0]     m_sel_s;
  logic [DATA_WIDTH-1:0]    m_dat_s;
  logic [ADDR_WIDTH-1:0]    m_adr_s;
  logic                     stb_live_s;
  logic                     timeout_s;
  logic                     ack_any_s;
  logic [DATA_WIDTH-1:0]    rd_dat_s;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  wb_rr_arb2 u_arb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .req_a   (wbs_a.cyc),
    .req_b   (wbs_b.cyc),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Select the granted master's request; everything is zero while idle
  always_comb begin
    m_cyc_s = 1'b0;
    m_stb_s = 1'b0;
    m_we_s  = 1'b0;
    m_sel_s = {SEL_WIDTH{1'b0}};
    m_dat_s = {DATA_WIDTH{1'b0}};
    m_adr_s = {ADDR_WIDTH{1'b0}};
    if (grant_a) begin
      m_cyc_s = wbs_a.cyc;
      m_stb_s = wbs_a.stb;
      m_we_s  = wbs_a.we;
      m_sel_s = wbs_a.sel;
      m_dat_s = wbs_a.dat_w;
      m_adr_s = wbs_a.adr;
    end else if (grant_b) begin
      m_cyc_s = wbs_b.cyc;
      m_stb_s = wbs_b.stb;
      m_we_s  = wbs_b.we;
      m_sel_s = wbs_b.sel;
      m_dat_s = wbs_b.dat_w;
      m_adr_s = wbs_b.adr;
    end else begin
      m_cyc_s = 1'b0;
    end
  end

  // A real ack in the limit cycle suppresses the forced termination
  assign stb_live_s = m_cyc_s & m_stb_s;
  assign timeout_s  = WD_EN & stb_live_s & ~wbm.ack & (wd_cnt == TO_LIMIT);

  assign wbm.cyc   = m_cyc_s & ~timeout_s;
  assign wbm.stb   = m_stb_s & ~timeout_s;
  assign wbm.we    = m_we_s;
  assign wbm.sel   = m_sel_s;
  assign wbm.dat_w = m_dat_s;
  assign wbm.adr   = m_adr_s;

  assign ack_any_s = (wbm.ack & wbm.stb) | timeout_s;
  assign rd_dat_s  = timeout_s ? TIMEOUT_DATA : wbm.dat_r;

  assign wbs_a.ack   = ack_any_s & grant_a;
  assign wbs_b.ack   = ack_any_s & grant_b;
  assign wbs_a.dat_r = grant_a ? rd_dat_s : 32'h0000_0000;
  assign wbs_b.dat_r = grant_b ? rd_dat_s : 32'h0000_0000;
  assign timeout_o   = timeout_s;

  // Watchdog: counts unacked strobe cycles; a dropped cyc also covers grant changes
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wd_cnt <= {TIMEOUT_WIDTH{1'b0}};
    end else if (!WD_EN || !stb_live_s || wbm.ack || timeout_s) begin
      wd_cnt <= {TIMEOUT_WIDTH{1'b0}};
    end else begin
      wd_cnt <= wd_cnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2way.sv
// Directed self-checking bench for wb_arbiter_2way with a 4-cycle watchdog.
module tb_wb_arbiter_2way;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout;
  int   n_cmp = 0;
  int   n_bad = 0;

  wb_arbiter_2way_if #(.ADDR_WIDTH(32)) a_if ();
  wb_arbiter_2way_if #(.ADDR_WIDTH(32)) b_if ();
  wb_arbiter_2way_if #(.ADDR_WIDTH(32)) m_if ();

  wb_arbiter_2way #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_WIDTH  (8),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_a     (a_if),
    .wbs_b     (b_if),
    .wbm       (m_if),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic on, input logic we, input logic [31:0] adr);
    a_if.cyc = on; a_if.stb = on; a_if.we = we; a_if.adr = adr;
  endtask

  task automatic req_b(input logic on, input logic we, input logic [31:0] adr);
    b_if.cyc = on; b_if.stb = on; b_if.we = we; b_if.adr = adr;
  endtask

  task automatic slave(input logic ack, input logic [31:0] dat);
    m_if.ack = ack; m_if.dat_r = dat;
  endtask

  initial begin
    req_a(1'b0, 1'b0, 32'h0); req_b(1'b0, 1'b0, 32'h0);
    a_if.sel = 4'hF; a_if.dat_w = 32'hAAAA_0001;
    b_if.sel = 4'h3; b_if.dat_w = 32'hBBBB_0002;
    slave(1'b0, 32'h0);
    step(); step();
    check_eq("rst_cyc", {31'd0, m_if.cyc}, 32'd0);
    check_eq("rst_adr", m_if.adr, 32'h0);
    check_eq("rst_ack_a", {31'd0, a_if.ack}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: A alone, read acked on second cycle
    req_a(1'b1, 1'b0, 32'h3000_0010);
    #1 check_eq("t1_arb_latency", {31'd0, m_if.cyc}, 32'd0);
    step();
    check_eq("t1_adr", m_if.adr, 32'h3000_0010);
    check_eq("t1_stb", {31'd0, m_if.stb}, 32'd1);
    check_eq("t1_noack", {31'd0, a_if.ack}, 32'd0);
    slave(1'b1, 32'h1234_5678);
    #1;
    check_eq("t1_ack_a", {31'd0, a_if.ack}, 32'd1);
    check_eq("t1_dat_a", a_if.dat_r, 32'h1234_5678);
    check_eq("t1_ack_b", {31'd0, b_if.ack}, 32'd0);
    check_eq("t1_dat_b", b_if.dat_r, 32'h0);
    step();
    req_a(1'b0, 1'b0, 32'h0); slave(1'b0, 32'h0);
    #1 check_eq("t1_cyc_drop", {31'd0, m_if.cyc}, 32'd0);
    step();

    // 2: tie from reset -> A, then B, next tie -> A
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_a(1'b1, 1'b0, 32'h0000_0100); req_b(1'b1, 1'b0, 32'h0000_0200);
    step();
    check_eq("t2_first_A", m_if.adr, 32'h0000_0100);
    slave(1'b1, 32'h0000_0011);
    #1 check_eq("t2_ack_a", {31'd0, a_if.ack}, 32'd1);
    check_eq("t2_noack_b", {31'd0, b_if.ack}, 32'd0);
    step();
    req_a(1'b0, 1'b0, 32'h0); slave(1'b0, 32'h0);
    step();
    check_eq("t2_then_B", m_if.adr, 32'h0000_0200);
    check_eq("t2_B_cyc", {31'd0, m_if.cyc}, 32'd1);
    slave(1'b1, 32'h0000_0022);
    #1 check_eq("t2_ack_b", {31'd0, b_if.ack}, 32'd1);
    check_eq("t2_dat_b", b_if.dat_r, 32'h0000_0022);
    step();
    req_b(1'b0, 1'b0, 32'h0); slave(1'b0, 32'h0);
    step();
    req_a(1'b1, 1'b0, 32'h0000_0104); req_b(1'b1, 1'b0, 32'h0000_0204);
    step();
    check_eq("t2_tie_A_again", m_if.adr, 32'h0000_0104);
    req_a(1'b0, 1'b0, 32'h0); req_b(1'b0, 1'b0, 32'h0);
    step(); step();

    // 3: A holds cyc over 3 beats while B waits
    req_a(1'b1, 1'b1, 32'h0000_0040);
    step();
    req_b(1'b1, 1'b0, 32'h0000_0900);
    for (int i = 0; i < 3; i++) begin
      a_if.adr = 32'h0000_0040 + 32'(i * 4);
      slave(1'b1, 32'h0);
      #1;
      check_eq("t3_beat_adr", m_if.adr, 32'h0000_0040 + 32'(i * 4));
      check_eq("t3_beat_ack_a", {31'd0, a_if.ack}, 32'd1);
      check_eq("t3_beat_ack_b", {31'd0, b_if.ack}, 32'd0);
      check_eq("t3_beat_we", {31'd0, m_if.we}, 32'd1);
      step();
    end
    req_a(1'b0, 1'b0, 32'h0); slave(1'b0, 32'h0);
    #1 check_eq("t3_b_stb_blocked", {31'd0, m_if.stb}, 32'd0);
    step();
    check_eq("t3_b_stb", {31'd0, m_if.stb}, 32'd1);
    check_eq("t3_b_adr", m_if.adr, 32'h0000_0900);
    req_b(1'b0, 1'b0, 32'h0);
    step(); step();

    // 4: slave never acks -> timeout on 5th strobe cycle
    req_a(1'b1, 1'b0, 32'h0000_0500);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_wait_to", {31'd0, timeout}, 32'd0);
      check_eq("t4_wait_ack", {31'd0, a_if.ack}, 32'd0);
      step();
    end
    check_eq("t4_timeout", {31'd0, timeout}, 32'd1);
    check_eq("t4_ack", {31'd0, a_if.ack}, 32'd1);
    check_eq("t4_dat", a_if.dat_r, 32'hDEAD_BEEF);
    check_eq("t4_cyc_abort", {31'd0, m_if.cyc}, 32'd0);
    check_eq("t4_stb_abort", {31'd0, m_if.stb}, 32'd0);
    req_a(1'b0, 1'b0, 32'h0);
    step();
    check_eq("t4_pulse_end", {31'd0, timeout}, 32'd0);
    step();

    // 5: ack lands exactly on the timeout cycle
    req_a(1'b1, 1'b0, 32'h0000_0600);
    step();
    for (int i = 0; i < 4; i++) step();
    slave(1'b1, 32'hCAFE_F00D);
    #1;
    check_eq("t5_no_timeout", {31'd0, timeout}, 32'd0);
    check_eq("t5_ack", {31'd0, a_if.ack}, 32'd1);
    check_eq("t5_dat", a_if.dat_r, 32'hCAFE_F00D);
    check_eq("t5_cyc", {31'd0, m_if.cyc}, 32'd1);
    step();
    req_a(1'b0, 1'b0, 32'h0); slave(1'b0, 32'h0);
    step(); step();

    // 6: reset during B write wait, then tie goes to A
    req_b(1'b1, 1'b1, 32'h0000_0700);
    step();
    check_eq("t6_b_we", {31'd0, m_if.we}, 32'd1);
    step();
    rst_n = 1'b0;
    step();
    check_eq("t6_rst_cyc", {31'd0, m_if.cyc}, 32'd0);
    check_eq("t6_rst_stb", {31'd0, m_if.stb}, 32'd0);
    check_eq("t6_rst_we", {31'd0, m_if.we}, 32'd0);
    check_eq("t6_rst_ack_b", {31'd0, b_if.ack}, 32'd0);
    rst_n = 1'b1;
    req_a(1'b1, 1'b0, 32'h0000_0800);
    step();
    check_eq("t6_tie_A", m_if.adr, 32'h0000_0800);
    check_eq("t6_noack_b", {31'd0, b_if.ack}, 32'd0);
    req_a(1'b0, 1'b0, 32'h0); req_b(1'b0, 1'b0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
